// File: rtl/cpu_sequencer.sv
// cpu_sequencer: run/halt/step controller for the accumulator CPU core.
// Stretches each instruction over FETCH / EXEC / COMMIT and emits a single
// commit pulse per instruction, with a PC breakpoint and a saturating
// committed-instruction counter for debug.
module cpu_sequencer #(
  parameter int PC_W        = 5,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_halt,
  input  logic             i_step,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_pc_addr,
  input  logic             i_mem_access,
  output logic             o_ce,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic             o_bp_hit,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Counter preload for a plain instruction; a memory access adds one cycle.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state, state_n;
  logic             step_mode, step_mode_n;
  logic             halt_pending, halt_pending_n;
  logic             resume, resume_n;
  logic             bp_hit, bp_hit_n;
  logic [3:0]       exec_cnt, exec_cnt_n;
  logic [CNT_W-1:0] instr_count, instr_count_n;
  logic             bp_match;

  // The breakpoint is ignored for the first fetch after leaving HALT so a
  // run/step can move off the breakpoint PC without trapping again.
  assign bp_match = i_bp_en && (i_pc_addr == i_bp_addr) && !resume;

  // Next-state and next-value logic for the sequencer and its debug state.
  always_comb begin
    state_n        = state;
    step_mode_n    = step_mode;
    halt_pending_n = halt_pending;
    resume_n       = resume;
    bp_hit_n       = bp_hit;
    exec_cnt_n     = exec_cnt;
    instr_count_n  = instr_count;

    case (state)
      ST_HALT: begin
        if (i_step) begin
          state_n        = ST_FETCH;
          step_mode_n    = 1'b1;
          resume_n       = 1'b1;
          bp_hit_n       = 1'b0;
          halt_pending_n = 1'b0;
        end else if (i_run && !i_halt) begin
          state_n        = ST_FETCH;
          step_mode_n    = 1'b0;
          resume_n       = 1'b1;
          bp_hit_n       = 1'b0;
          halt_pending_n = 1'b0;
        end
      end

      ST_FETCH: begin
        if (bp_match) begin
          state_n        = ST_HALT;
          bp_hit_n       = 1'b1;
          halt_pending_n = 1'b0;
        end else begin
          state_n    = ST_EXEC;
          exec_cnt_n = EXEC_LOAD + {3'b000, i_mem_access};
          if (i_halt) begin
            halt_pending_n = 1'b1;
          end
        end
      end

      ST_EXEC: begin
        if (i_halt) begin
          halt_pending_n = 1'b1;
        end
        if (exec_cnt == 4'd0) begin
          state_n = ST_COMMIT;
        end else begin
          exec_cnt_n = exec_cnt - 4'd1;
        end
      end

      ST_COMMIT: begin
        resume_n = 1'b0;
        if (instr_count != {CNT_W{1'b1}}) begin
          instr_count_n = instr_count + CNT_W'(1);
        end
        if (step_mode || halt_pending || i_halt) begin
          state_n        = ST_HALT;
          halt_pending_n = 1'b0;
        end else begin
          state_n = ST_FETCH;
        end
      end

      default: begin
        state_n = ST_HALT;
      end
    endcase
  end

  // State and debug registers; reset wins over every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_HALT;
      step_mode    <= 1'b0;
      halt_pending <= 1'b0;
      resume       <= 1'b0;
      bp_hit       <= 1'b0;
      exec_cnt     <= 4'd0;
      instr_count  <= '0;
    end else begin
      state        <= state_n;
      step_mode    <= step_mode_n;
      halt_pending <= halt_pending_n;
      resume       <= resume_n;
      bp_hit       <= bp_hit_n;
      exec_cnt     <= exec_cnt_n;
      instr_count  <= instr_count_n;
    end
  end

  assign o_ce          = (state == ST_COMMIT);
  assign o_halted      = (state == ST_HALT);
  assign o_state       = state;
  assign o_bp_hit      = bp_hit;
  assign o_instr_count = instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: expected commit pulses are queued
// when stimulus is driven and matched against each o_ce the DUT produces.
module tb_cpu_sequencer;

  localparam int PC_W  = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             run;
  logic             halt;
  logic             step;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             mem;
  logic             ce;
  logic [1:0]       state;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] count;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int cycle;
    int count;
  } commit_t;

  commit_t sb[$];

  cpu_sequencer #(
    .PC_W(PC_W),
    .EXEC_CYCLES(2),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_run(run),
    .i_halt(halt),
    .i_step(step),
    .i_bp_en(bp_en),
    .i_bp_addr(bp_addr),
    .i_pc_addr(pc),
    .i_mem_access(mem),
    .o_ce(ce),
    .o_state(state),
    .o_halted(halted),
    .o_bp_hit(bp_hit),
    .o_instr_count(count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index; the value seen at a falling edge names the current cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic s);
    run  = r;
    halt = h;
    step = s;
  endtask

  task automatic expectCommit(input int at_cycle, input int cnt_before);
    commit_t e;
    e.cycle = at_cycle;
    e.count = cnt_before;
    sb.push_back(e);
  endtask

  // Scoreboard side: every commit pulse must match the oldest queued entry.
  always @(negedge clk) begin
    commit_t e;
    if (ce === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("ce_not_expected", {31'b0, ce}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ce_cycle", cyc, e.cycle);
        checkOutput("count_at_ce", {28'b0, count}, e.count);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bp_en = 1'b0;
    bp_addr = '0;
    pc = '0;
    mem = 1'b0;
    tick(2);
    rst = 1'b0;

    // Idle after reset.
    tick(10);
    checkOutput("idle_halted", {31'b0, halted}, 32'd1);
    checkOutput("idle_state", {30'b0, state}, 32'd0);
    checkOutput("idle_count", {28'b0, count}, 32'd0);
    checkOutput("idle_bp_hit", {31'b0, bp_hit}, 32'd0);
    checkOutput("idle_ce", {31'b0, ce}, 32'd0);

    // Single step, no memory access: commit 4 cycles after the step.
    n = cyc;
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectCommit(n + 4, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("step_fetch_state", {30'b0, state}, 32'd1);
    checkOutput("step_not_halted", {31'b0, halted}, 32'd0);
    tick(4);
    checkOutput("step_back_halt", {31'b0, halted}, 32'd1);
    checkOutput("step_count", {28'b0, count}, 32'd1);

    // Single step with memory access: one extra execute cycle.
    mem = 1'b1;
    n = cyc;
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectCommit(n + 5, 1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(5);
    checkOutput("memstep_halted", {31'b0, halted}, 32'd1);
    checkOutput("memstep_count", {28'b0, count}, 32'd2);
    mem = 1'b0;

    // Continuous run, halt raised mid-EXEC of the sixth instruction.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst_count", {28'b0, count}, 32'd0);
    n = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) expectCommit(n + 4 * k, k - 1);
    tick(22);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("run_halted", {31'b0, halted}, 32'd1);
    checkOutput("run_count", {28'b0, count}, 32'd6);
    tick(6);
    checkOutput("run_stays_halted", {31'b0, halted}, 32'd1);

    // Breakpoint at PC 3; run is only pulsed, execution must continue.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bp_en = 1'b1;
    bp_addr = 5'd3;
    pc = 5'd0;
    n = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectCommit(n + 4, 0);
    expectCommit(n + 8, 1);
    expectCommit(n + 12, 2);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    pc = 5'd1;
    tick(4);
    pc = 5'd2;
    tick(4);
    pc = 5'd3;
    tick(1);
    checkOutput("bp_fetch_state", {30'b0, state}, 32'd1);
    tick(1);
    checkOutput("bp_halted", {31'b0, halted}, 32'd1);
    checkOutput("bp_hit_set", {31'b0, bp_hit}, 32'd1);
    checkOutput("bp_count", {28'b0, count}, 32'd3);

    // Resume from the breakpoint PC: no re-trap, bp_hit cleared.
    n = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectCommit(n + 4, 3);
    expectCommit(n + 8, 4);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_bp_cleared", {31'b0, bp_hit}, 32'd0);
    tick(3);
    pc = 5'd4;
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("resume_halted", {31'b0, halted}, 32'd1);
    checkOutput("resume_count", {28'b0, count}, 32'd5);

    // Reset during EXEC aborts the instruction.
    bp_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("exec_before_rst", {30'b0, state}, 32'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst_ce", {31'b0, ce}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted}, 32'd1);
    checkOutput("rst_state", {30'b0, state}, 32'd0);
    checkOutput("rst_count_exec", {28'b0, count}, 32'd0);
    checkOutput("rst_bp_hit", {31'b0, bp_hit}, 32'd0);
    tick(6);

    // Counter saturation; a step pulse while running is ignored.
    n = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) expectCommit(n + 4 * k, (k - 1 > 15) ? 15 : k - 1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(9);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(51);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("sat_halted", {31'b0, halted}, 32'd1);
    checkOutput("sat_count", {28'b0, count}, 32'd15);
    tick(4);

    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
